// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and its clients
// (controller FSM, datapath, test benches).
package lime_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the multi-cycle controller (master)
// and the memory responder (slave).
interface mem_responder_if;
  import lime_mem_pkg::*;

  logic              MemR;
  logic              MemW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output MemR, MemW, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  MemR, MemW, addr, wdata,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/mem_responder_mem_array_sp.sv
// Single-port synchronous word store with a registered read port.
// Kept apart from the control FSM so the storage maps cleanly onto RAM.
module mem_array_sp
  import lime_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Store write port.
  // NOTE: the storage array has no reset; a reset loop over every word would
  // stop it mapping to RAM, and its contents must survive Reset_n anyway.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read-data register: cleared on reset or on an out-of-range read, loaded on a legal read.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one MemR/MemW request at a time, waits
// WAIT_CYCLES, services it against the word store and reports completion
// with a one-cycle ready pulse (qualified by err for rejected requests).
module mem_responder
  import lime_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2     // legal range 0..15
) (
  input  logic           CLK,
  input  logic           Reset_n,
  mem_responder_if.slave bus
);

  mem_state_t        state, state_next;
  logic              accept;
  logic [3:0]        cnt;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q, err_q;
  logic              resp, illegal, oor;
  logic              arr_we, arr_re, arr_clr;

  // Next-state logic; requests are only looked at in IDLE.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MemR || bus.MemW) begin
          accept     = 1'b1;
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Request latches: captured at accept, frozen for the rest of the access.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_q    <= bus.MemR;
      wr_q    <= bus.MemW;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  assign resp    = (state == RESP);
  assign illegal = rd_q & wr_q;
  assign oor     = |addr_q[ADDR_W-1:DEPTH_LOG2];

  // Store operations all happen on the edge that leaves RESP.
  assign arr_we  = resp & wr_q & ~rd_q & ~oor;
  assign arr_re  = resp & rd_q & ~wr_q & ~oor;
  assign arr_clr = resp & rd_q & ~wr_q &  oor;

  mem_array_sp #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .we      (arr_we),
    .re      (arr_re),
    .clr     (arr_clr),
    .addr    (addr_q[DEPTH_LOG2-1:0]),
    .wdata   (wdata_q),
    .q       (bus.rdata)
  );

  // Completion pulse, aligned with the registered read data.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= resp;
      err_q   <= resp & (illegal | oor);
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state != IDLE) | ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none; a scoreboard queue holds the expected response of each
// request and is popped on every ready pulse.
module tb_mem_responder;
  import lime_mem_pkg::*;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  always #5 CLK = ~CLK;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .CLK (CLK), .Reset_n (Reset_n), .bus (bus2)
  );

  mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .CLK (CLK), .Reset_n (Reset_n), .bus (bus0)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    bit          chk_rdata;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit sel0, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd);
    if (sel0) begin
      bus0.MemR = rd; bus0.MemW = wr; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus2.MemR = rd; bus2.MemW = wr; bus2.addr = a; bus2.wdata = wd;
    end
  endtask

  function automatic logic get_ready(input bit sel0);
    return sel0 ? bus0.ready : bus2.ready;
  endfunction
  function automatic logic get_err(input bit sel0);
    return sel0 ? bus0.err : bus2.err;
  endfunction
  function automatic logic get_busy(input bit sel0);
    return sel0 ? bus0.busy : bus2.busy;
  endfunction
  function automatic logic [15:0] get_rdata(input bit sel0);
    return sel0 ? bus0.rdata : bus2.rdata;
  endfunction

  // Pop the oldest expectation and compare it with the response on the bus.
  task automatic score(input bit sel0, input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_err"}, get_err(sel0), e.err);
      if (e.chk_rdata) check({tag, "_rdata"}, get_rdata(sel0), e.rdata);
    end
  endtask

  // One access: request held until ready, addr/wdata scrambled after accept.
  task automatic access(input bit sel0, input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err,
                        input bit chk_rd, input int exp_lat);
    exp_t e;
    int   lat    = 0;
    int   busy_n = 0;
    bit   got    = 0;
    e.rdata = exp_rd; e.err = exp_err; e.chk_rdata = chk_rd;
    sb_q.push_back(e);
    @(negedge CLK);
    set_req(sel0, rd, wr, a, wd);
    @(posedge CLK);
    while (!got && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (get_busy(sel0)) busy_n++;
      if (get_ready(sel0)) begin
        got = 1;
        set_req(sel0, 1'b0, 1'b0, a, wd);
        score(sel0, tag);
      end else if (lat == 1) begin
        set_req(sel0, rd, wr, ~a, ~wd);
      end
    end
    check({tag, "_done"}, 32'(got), 1);
    if (!got && sb_q.size() != 0) void'(sb_q.pop_back());
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat);
    @(negedge CLK);
    check({tag, "_ready_fall"}, get_ready(sel0), 1'b0);
    check({tag, "_err_low"}, get_err(sel0), 1'b0);
    check({tag, "_busy_fall"}, get_busy(sel0), 1'b0);
    if (chk_rd) check({tag, "_rdata_held"}, get_rdata(sel0), exp_rd);
  endtask

  // Request held high across n ready pulses; pulse spacing must equal exp_gap.
  task automatic stream(input bit sel0, input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err,
                        input bit chk_rd, input int n, input int exp_gap);
    exp_t e;
    int   seen  = 0;
    int   cyc   = 0;
    int   last  = -1;
    int   stray = 0;
    e.rdata = exp_rd; e.err = exp_err; e.chk_rdata = chk_rd;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
    @(negedge CLK);
    set_req(sel0, rd, wr, a, wd);
    while (seen < n && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (get_ready(sel0)) begin
        score(sel0, tag);
        if (last >= 0) check({tag, "_gap"}, cyc - last, exp_gap);
        last = cyc;
        seen++;
        if (seen == n) set_req(sel0, 1'b0, 1'b0, a, wd);
      end
    end
    check({tag, "_pulses"}, seen, n);
    while (sb_q.size() != 0) void'(sb_q.pop_front());
    repeat (exp_gap + 2) begin
      @(negedge CLK);
      if (get_ready(sel0)) stray++;
    end
    check({tag, "_no_extra_ready"}, stray, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset state.
    Reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      check("rst_rdata", get_rdata(s[0]), 16'h0);
      check("rst_ready", get_ready(s[0]), 1'b0);
      check("rst_err",   get_err(s[0]),   1'b0);
      check("rst_busy",  get_busy(s[0]),  1'b0);
    end
    Reset_n = 1'b1;
    @(negedge CLK);

    // 1-2: write then read back, two wait states -> ready in cycle 4.
    access(0, "t1_write", 1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 1, 4);
    access(0, "t2_read",  1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1, 4);

    // 3: both strobes -> err, no store access, rdata unchanged.
    access(0, "t3_both",  1'b1, 1'b1, 16'h0005, 16'h1234, 16'hBEEF, 1'b1, 1, 4);
    access(0, "t3_read",  1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1, 4);

    // 4: out-of-range read and write; word 0 must be left alone.
    access(0, "t4_wr0",   1'b0, 1'b1, 16'h0000, 16'h1111, 16'hBEEF, 1'b0, 1, 4);
    access(0, "t4_rdoor", 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1, 4);
    access(0, "t4_wroor", 1'b0, 1'b1, 16'h0400, 16'h5A5A, 16'h0000, 1'b1, 1, 4);
    access(0, "t4_rd0",   1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 1, 4);

    // 5: reset during WAIT aborts a pending write.
    access(0, "t5_wr7",   1'b0, 1'b1, 16'h0007, 16'h3333, 16'h1111, 1'b0, 1, 4);
    @(negedge CLK);
    set_req(0, 1'b0, 1'b1, 16'h0007, 16'h00AA);
    @(posedge CLK);
    @(negedge CLK);
    check("t5_busy_in_wait", get_busy(0), 1'b1);
    Reset_n = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge CLK);
      if (get_ready(0)) stray++;
    end
    check("t5_busy_in_reset",  get_busy(0),  1'b0);
    check("t5_rdata_in_reset", get_rdata(0), 16'h0);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (get_ready(0)) stray++;
    end
    check("t5_no_ready", stray, 0);
    access(0, "t5_rd7",   1'b1, 1'b0, 16'h0007, 16'h0000, 16'h3333, 1'b0, 1, 4);

    // 6: request held across ready -> back-to-back accesses.
    stream(0, "t6_w2_rd", 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1, 3, 4);
    stream(1, "t6_w0_wr", 1'b0, 1'b1, 16'h0009, 16'h4242, 16'h0000, 1'b0, 1, 2, 2);
    stream(1, "t6_w0_rd", 1'b1, 1'b0, 16'h0009, 16'h0000, 16'h4242, 1'b0, 1, 3, 2);
    access(1, "t6_w0_oor", 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
